alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational 8-bit ALU between two requesters. It accepts operation requests over valid/ready handshakes, arbitrates round-robin, and drives the ALU operand and select inputs from registers. It then captures the ALU result and returns it on a per-requester response handshake. It sits between the requester blocks and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- `W`, default 8: operand and result width. Must match the ALU.
- `clk`  in  1: single clock; everything is rising-edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  2: bit i is high when requester i has an operation pending.
- `req_ready`  out  2: bit i is the one-cycle accept strobe for requester i.
- `req_a`  in  2*W: operand A; requester i uses `[i*W +: W]`.
- `req_b`  in  2*W: operand B, same packing as `req_a`.
- `req_sel`  in  8: 4-bit opcode per requester, `[i*4 +: 4]`.
- `rsp_valid`  out  2: bit i is high when the response for requester i is available.
- `rsp_ready`  in  2: bit i is high when requester i takes the response.
- `rsp_result`  out  W: result, shared by both requesters; qualified by `rsp_valid`.
- `rsp_carry`  out  1: carry/borrow. Valid only for the add and subtract opcodes; 0 for all others.
- `rsp_err`  out  1: error flag. Meaningful only with the Configuration macro; otherwise tied to 0.
- `alu_a`, `alu_b`  out  W each: registered operand drive to the ALU.
- `alu_sel`  out  4: registered opcode drive to the ALU.
- `alu_result`  in  W: ALU result.
- `alu_carry`  in  1: ALU carry.

## Operation
- FSM states: IDLE, EXEC, RESP. The state encoding is registered.
- **IDLE**
  - If any `req_valid` bit is high, compute the grant g round-robin: the requester other than `last` wins a tie; a lone requester always wins.
  - Assert `req_ready[g]` combinationally in this cycle.
  - Latch `req_a`, `req_b` and `req_sel` slice g into `alu_a`, `alu_b` and `alu_sel`.
  - Set `last` to g and move to EXEC.
- **EXEC**
  - `alu_*` are stable for the whole cycle.
  - At the clock edge, capture `alu_result` into `rsp_result`.
  - Capture `rsp_carry` as `alu_carry` if `alu_sel` is 4'b0000 or 4'b0001; otherwise 0.
  - Move to RESP.
- **RESP**
  - Hold `rsp_valid[g]` high, with all `rsp_*` stable, until `rsp_ready[g]` is high at an edge.
  - Then return to IDLE.
  - `req_ready` stays 0 in this state.
- `req_ready` is only ever asserted in IDLE, and at most one bit at a time.
- `rsp_ready` is ignored whenever the matching `rsp_valid` bit is low.
- Requesters must hold valid and payload until `req_ready`. The arbiter does not check this.
- `alu_*` hold their last value in IDLE and RESP; no toggling occurs without a new grant.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_carry` = 0, `rsp_err` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_sel` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - State = IDLE.

## Timing
- Accept at edge T (`req_ready` high in cycle T). EXEC runs in cycle T+1, and `rsp_valid` rises in cycle T+2.
- Minimum issue interval is 3 cycles per operation, reached when `rsp_ready` is already high.
- Back-to-back ties alternate 0,1,0,1…
- A requester that keeps `req_valid` high is served no more than every other grant while the other requester is also requesting.
- Reset asserted in any state returns to IDLE at the next edge. Any in-flight operation is dropped, and no response is issued for it.
- `req_valid` arriving while the FSM is in RESP waits. It is evaluated in the first IDLE cycle.

## Configuration
- Macro: `ALU_ARB_DIV0_CHECK_EN`.
- **With the macro defined:** a granted operation with `alu_sel` = 4'b0011 and `alu_b` = 0 skips EXEC.
  - RESP is entered directly, with `rsp_result` = {W{1'b1}}, `rsp_carry` = 0 and `rsp_err` = 1.
  - Latency is T+1 instead of T+2.
  - `rsp_err` is 0 for every other operation.
- **Without the macro:** divide-by-zero is issued to the ALU like any other operation, and `rsp_err` is constant 0.

## Structure
- A shared package `alu_pkg` holds:
  - the 4-bit opcode localparams (`OP_ADD` = 4'b0000 … `OP_XNOR` = 4'b1111);
  - the FSM state constants;
  - the default `W`.
- One sub-module, `rr_arb2`, is natural. It is a two-way round-robin grant with inputs `req[1:0]` and `last`, and outputs `gnt[1:0]`. It is purely combinational; `last` is stored in the parent.
- The ALU itself is instantiated outside this block.

## Test plan
- **Single request.** Requester 0 sends A=8'd200, B=8'd100, sel=0000, with `rsp_ready` high. Expect `req_ready[0]` at T, then `rsp_valid[0]` at T+2 with result 8'd44 and carry=1.
- **Simultaneous requests.** Both requesters are valid from reset, each running 4 ops. Expect grants in the order 0,1,0,1,0,1,0,1, each requester receiving its own results, and `rsp_valid` never high on both bits at once.
- **Response backpressure.** Hold `rsp_ready[1]` low for 5 cycles on a sel=1010 op. Expect `rsp_valid[1]` and `rsp_result` to stay stable throughout, `req_ready` to stay 0, and return to IDLE one edge after `rsp_ready` rises.
- **Reset mid-operation.** Assert `rst_n` low during EXEC. Expect no `rsp_valid`, all outputs at their reset values, and the next tie to go to requester 0.
- **Divide by zero with `ALU_ARB_DIV0_CHECK_EN`.** Send A=8'd9, B=0, sel=0011. Expect `rsp_valid` at T+1 with result 8'hFF and `rsp_err`=1.
- **Divide by zero without the macro.** The same stimulus gives `rsp_valid` at T+2 and `rsp_err`=0.
- **Carry masking.** Send sel=0101 with A=8'h81, B=1. Expect result 8'h02 and carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and width definitions for the ALU arbiter.
package alu_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_ROR  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_NOT  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_NOR  = 4'b1110;
  localparam logic [3:0] OP_XNOR = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the requester other than `last` wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional divide-by-zero short-circuit: define ALU_ARB_DIV0_CHECK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [7:0]     req_sel,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_sel,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carry
);

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [1:0]     owner_q, owner_d;
  logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_q, carry_d;
  logic [1:0]     gnt;
  logic [W-1:0]   pick_a, pick_b;
  logic [3:0]     pick_sel;

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign pick_a   = gnt[1] ? req_a[W +: W]  : req_a[0 +: W];
  assign pick_b   = gnt[1] ? req_b[W +: W]  : req_b[0 +: W];
  assign pick_sel = gnt[1] ? req_sel[4 +: 4] : req_sel[0 +: 4];

`ifdef ALU_ARB_DIV0_CHECK_EN
  logic err_q, err_d;
  logic div0;
  assign div0    = (pick_sel == OP_DIV) && (pick_b == '0);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    carry_d   = carry_q;
`ifdef ALU_ARB_DIV0_CHECK_EN
    err_d     = err_q;
`endif
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready = gnt;
          last_d    = gnt[1];
          owner_d   = gnt;
          alu_a_d   = pick_a;
          alu_b_d   = pick_b;
          alu_sel_d = pick_sel;
          state_d   = StExec;
`ifdef ALU_ARB_DIV0_CHECK_EN
          // Divide-by-zero never reaches the ALU result path.
          if (div0) begin
            result_d = '1;
            carry_d  = 1'b0;
            err_d    = 1'b1;
            state_d  = StResp;
          end
`endif
        end
      end
      StExec: begin
        result_d = alu_result;
        carry_d  = ((alu_sel_q == OP_ADD) || (alu_sel_q == OP_SUB)) ? alu_carry : 1'b0;
`ifdef ALU_ARB_DIV0_CHECK_EN
        err_d    = 1'b0;
`endif
        state_d  = StResp;
      end
      StResp: begin
        rsp_valid = owner_q;
        if (|(owner_q & rsp_ready)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 2'b00;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
`ifdef ALU_ARB_DIV0_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
`ifdef ALU_ARB_DIV0_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter, with a behavioural 8-bit ALU stub.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic [7:0]  rsp_result, alu_a, alu_b, alu_result;
  logic        rsp_carry, rsp_err, alu_carry;
  logic [3:0]  alu_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  // ALU stub: non-arithmetic ops drive carry high so masking is observable.
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b1;
    case (alu_sel)
      4'h0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: begin alu_result = alu_a - alu_b; alu_carry = alu_a < alu_b; end
      4'h2: alu_result = alu_a * alu_b;
      4'h3: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      4'h4: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a % alu_b;
      4'h5: alu_result = alu_a << alu_b[2:0];
      4'h6: alu_result = alu_a >> alu_b[2:0];
      4'h9: alu_result = alu_a & alu_b;
      4'hA: alu_result = alu_a | alu_b;
      4'hB: alu_result = alu_a ^ alu_b;
      4'hC: alu_result = ~alu_a;
      4'hD: alu_result = ~(alu_a & alu_b);
      4'hE: alu_result = ~(alu_a | alu_b);
      4'hF: alu_result = ~(alu_a ^ alu_b);
      default: alu_result = alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] sel);
    req_a[idx*8 +: 8]   = a;
    req_b[idx*8 +: 8]   = b;
    req_sel[idx*4 +: 4] = sel;
  endtask

  // Single operation with rsp_ready already high; elat counts cycles after the accept edge.
  task automatic do_op(input string tag, input int idx, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] sel, input logic [7:0] er,
                       input logic ec, input logic ee, input int elat);
    int lat;
    lat = 0;
    load(idx, a, b, sel);
    req_valid[idx] = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 32'(2'b01 << idx));
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_valid"}, rsp_valid, 32'(2'b01 << idx));
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_carry"}, rsp_carry, ec);
    check({tag, "_err"}, rsp_err, ee);
    check({tag, "_alu"}, {alu_a, alu_b, alu_sel}, {a, b, sel});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_out"}, {rsp_result, rsp_carry, rsp_err}, 0);
    check({tag, "_alu_out"}, {alu_a, alu_b, alu_sel}, 0);
  endtask

  logic [7:0] t_a   [2][4];
  logic [7:0] t_b   [2][4];
  logic [3:0] t_sel [2][4];
  logic [7:0] t_res [2][4];
  logic       t_c   [2][4];
  int         n     [2];

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 200 + 100 = 300 -> 44 with carry out.
    do_op("single", 0, 8'd200, 8'd100, 4'b0000, 8'd44, 1'b1, 1'b0, 2);
    // Shift carries out a 1 from the stub, but carry is masked for non add/sub.
    do_op("carrymask", 1, 8'h81, 8'h01, 4'b0101, 8'h02, 1'b0, 1'b0, 2);
`ifdef ALU_ARB_DIV0_CHECK_EN
    do_op("div0", 0, 8'd9, 8'd0, 4'b0011, 8'hFF, 1'b0, 1'b1, 1);
`else
    do_op("div0", 0, 8'd9, 8'd0, 4'b0011, 8'hFF, 1'b0, 1'b0, 2);
`endif
    do_op("div", 1, 8'd9, 8'd2, 4'b0011, 8'd4, 1'b0, 1'b0, 2);

    // Backpressure on requester 1; requester 0 arrives during EXEC and must wait.
    rsp_ready = 2'b01;
    load(1, 8'h0F, 8'h30, 4'b1010);
    req_valid[1] = 1'b1;
    @(negedge clk);
    check("bp_ready", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    load(0, 8'd1, 8'd2, 4'b0000);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("bp_exec_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 2'b10);
      check("bp_hold_result", {rsp_result, rsp_carry}, {8'h3F, 1'b0});
      check("bp_hold_ready", req_ready, 0);
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_next_valid", rsp_valid, 2'b01);
    check("bp_next_result", rsp_result, 8'd3);
    @(posedge clk);
    #1;

    // Reset during EXEC drops the operation.
    load(1, 8'd3, 8'd4, 4'b0000);
    req_valid[1] = 1'b1;
    @(negedge clk);
    check("midrst_ready", req_ready, 2'b10);
    @(posedge clk);
    #1 begin
      req_valid[1] = 1'b0;
      rst_n        = 1'b0;
    end
    @(negedge clk);
    check("midrst_exec_valid", rsp_valid, 0);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters contend; the first tie after reset goes to requester 0.
    t_a = '{'{8'd10, 8'd5, 8'hF0, 8'hAA}, '{8'd7, 8'd50, 8'hFF, 8'h0F}};
    t_b = '{'{8'd20, 8'd7, 8'h3C, 8'hFF}, '{8'd6, 8'd20, 8'h01, 8'hF0}};
    t_sel = '{'{4'h0, 4'h1, 4'h9, 4'hB}, '{4'h2, 4'h1, 4'h0, 4'hE}};
    t_res = '{'{8'h1E, 8'hFE, 8'h30, 8'h55}, '{8'h2A, 8'h1E, 8'h00, 8'h00}};
    t_c   = '{'{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1, 1'b0}};
    n = '{0, 0};
    for (int r = 0; r < 2; r++) load(r, t_a[r][0], t_b[r][0], t_sel[r][0]);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      int e;
      e = k % 2;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (req_ready != 2'b00) break;
      end
      check("rr_grant", req_ready, 32'(2'b01 << e));
      @(posedge clk);
      #1 begin
        n[e]++;
        if (n[e] < 4) load(e, t_a[e][n[e]], t_b[e][n[e]], t_sel[e][n[e]]);
        else req_valid[e] = 1'b0;
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) break;
      end
      check("rr_rsp_valid", rsp_valid, 32'(2'b01 << e));
      check("rr_result", {rsp_result, rsp_carry}, {t_res[e][n[e]-1], t_c[e][n[e]-1]});
      check("rr_err", rsp_err, 0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
